// File: rtl/seg7.sv
// Registered 7-segment decoder: one-cycle latency, lamp-test/blank overrides,
// optional hex glyphs and selectable segment polarity.
module seg7 #(
  parameter bit HEX_MODE   = 1'b1,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       lamp_test,
  output logic [6:0] leds,
  output logic       bcd_err,
  output logic       valid
);

  localparam logic [6:0] DARK = ACTIVE_LOW ? 7'b1111111 : 7'b0000000;

  logic [6:0] pat_low_next;
  logic [6:0] leds_next;
  logic       err_next;
  logic [6:0] leds_reg;
  logic       bcd_err_reg;
  logic       valid_reg;

  // Patterns are kept in the board's native active-low form (gfedcba).
  always_comb begin
    pat_low_next = 7'b1111111;
    err_next     = 1'b0;
    if (lamp_test) begin
      pat_low_next = 7'b0000000;
    end else if (blank) begin
      pat_low_next = 7'b1111111;
    end else begin
      case (bcd)
        4'd0:  pat_low_next = 7'b1000000;
        4'd1:  pat_low_next = 7'b1111001;
        4'd2:  pat_low_next = 7'b0100100;
        4'd3:  pat_low_next = 7'b0110000;
        4'd4:  pat_low_next = 7'b0011001;
        4'd5:  pat_low_next = 7'b0010010;
        4'd6:  pat_low_next = 7'b0000010;
        4'd7:  pat_low_next = 7'b1111000;
        4'd8:  pat_low_next = 7'b0000000;
        4'd9:  pat_low_next = 7'b0010000;
        4'd10: pat_low_next = 7'b0001000;
        4'd11: pat_low_next = 7'b0000011;
        4'd12: pat_low_next = 7'b1000110;
        4'd13: pat_low_next = 7'b0100001;
        4'd14: pat_low_next = 7'b0000110;
        default: pat_low_next = 7'b0001110;
      endcase
      if (!HEX_MODE && bcd > 4'd9) begin
        pat_low_next = 7'b1111111;
        err_next     = 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_polarity
      if (ACTIVE_LOW) begin : g_low
        assign leds_next[gi] = pat_low_next[gi];
      end else begin : g_high
        assign leds_next[gi] = ~pat_low_next[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      leds_reg    <= DARK;
      bcd_err_reg <= 1'b0;
      valid_reg   <= 1'b0;
    end else begin
      valid_reg <= en;
      if (en) begin
        leds_reg    <= leds_next;
        bcd_err_reg <= err_next;
      end
    end
  end

  assign leds    = leds_reg;
  assign bcd_err = bcd_err_reg;
  assign valid   = valid_reg;

endmodule

// File: tb/tb_seg7.sv
// Self-checking bench for seg7: four parameter variants driven in parallel and
// compared against a segment-letter reference model.
module tb_seg7;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic [3:0] bcd;
  logic       blank;
  logic       lamp_test;

  logic [6:0] leds_o  [4];
  logic       err_o   [4];
  logic       valid_o [4];

  logic [6:0] exp_leds  [4];
  logic       exp_err   [4];
  logic       exp_valid [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Variant 0: hex/active-low, 1: bcd/active-low, 2: hex/active-high, 3: bcd/active-high
  seg7 #(.HEX_MODE(1'b1), .ACTIVE_LOW(1'b1)) u0 (.clk(clk), .reset_n(reset_n), .en(en), .bcd(bcd),
    .blank(blank), .lamp_test(lamp_test), .leds(leds_o[0]), .bcd_err(err_o[0]), .valid(valid_o[0]));
  seg7 #(.HEX_MODE(1'b0), .ACTIVE_LOW(1'b1)) u1 (.clk(clk), .reset_n(reset_n), .en(en), .bcd(bcd),
    .blank(blank), .lamp_test(lamp_test), .leds(leds_o[1]), .bcd_err(err_o[1]), .valid(valid_o[1]));
  seg7 #(.HEX_MODE(1'b1), .ACTIVE_LOW(1'b0)) u2 (.clk(clk), .reset_n(reset_n), .en(en), .bcd(bcd),
    .blank(blank), .lamp_test(lamp_test), .leds(leds_o[2]), .bcd_err(err_o[2]), .valid(valid_o[2]));
  seg7 #(.HEX_MODE(1'b0), .ACTIVE_LOW(1'b0)) u3 (.clk(clk), .reset_n(reset_n), .en(en), .bcd(bcd),
    .blank(blank), .lamp_test(lamp_test), .leds(leds_o[3]), .bcd_err(err_o[3]), .valid(valid_o[3]));

  function automatic bit hex_of(int v);
    return (v == 0) || (v == 2);
  endfunction

  function automatic bit low_of(int v);
    return v < 2;
  endfunction

  // Which segments a glyph lights, spelled with the usual segment letters.
  function automatic string glyph(int code);
    case (code)
      0: return "abcdef";   1: return "bc";      2: return "abdeg";  3: return "abcdg";
      4: return "bcfg";     5: return "acdfg";   6: return "acdefg"; 7: return "abc";
      8: return "abcdefg";  9: return "abcdfg";  10: return "abcefg"; 11: return "cdefg";
      12: return "adef";    13: return "bcdeg";  14: return "adefg";
      default: return "aefg";
    endcase
  endfunction

  function automatic logic [6:0] lit_mask(string s);
    logic [6:0] m = '0;
    for (int i = 0; i < s.len(); i++) m[s[i] - "a"] = 1'b1;
    return m;
  endfunction

  function automatic logic [6:0] drive(bit low, logic [6:0] lit);
    return low ? ~lit : lit;
  endfunction

  task automatic model_edge();
    for (int v = 0; v < 4; v++) begin
      if (!reset_n) begin
        exp_leds[v] = drive(low_of(v), 7'b0);
        exp_err[v] = 1'b0;
        exp_valid[v] = 1'b0;
      end else begin
        exp_valid[v] = en;
        if (en) begin
          exp_err[v] = 1'b0;
          if (lamp_test) exp_leds[v] = drive(low_of(v), 7'b1111111);
          else if (blank) exp_leds[v] = drive(low_of(v), 7'b0);
          else if (bcd > 9 && !hex_of(v)) begin
            exp_leds[v] = drive(low_of(v), 7'b0);
            exp_err[v] = 1'b1;
          end else exp_leds[v] = drive(low_of(v), lit_mask(glyph(int'(bcd))));
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, want);
    end
  endtask

  // Apply inputs, take one edge, then compare every variant against the model.
  task automatic step(input string tag, input logic rn, input logic e, input logic [3:0] d,
                      input logic bl, input logic lt);
    reset_n = rn; en = e; bcd = d; blank = bl; lamp_test = lt;
    @(posedge clk);
    #1;
    model_edge();
    for (int v = 0; v < 4; v++) begin
      check($sformatf("%s v%0d leds", tag, v), {25'b0, leds_o[v]}, {25'b0, exp_leds[v]});
      check($sformatf("%s v%0d err", tag, v), {31'b0, err_o[v]}, {31'b0, exp_err[v]});
      check($sformatf("%s v%0d valid", tag, v), {31'b0, valid_o[v]}, {31'b0, exp_valid[v]});
    end
    $display("txn %-8s rst_n=%b en=%b bcd=%0d blank=%b lamp=%b | leds=%b/%b/%b/%b err=%b%b%b%b valid=%b",
             tag, rn, e, d, bl, lt, leds_o[0], leds_o[1], leds_o[2], leds_o[3],
             err_o[0], err_o[1], err_o[2], err_o[3], valid_o[0]);
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b1; bcd = 4'd8; blank = 1'b0; lamp_test = 1'b0;
    #2;
    step("reset", 1'b0, 1'b1, 4'd8, 1'b0, 1'b0);
    step("reset", 1'b0, 1'b1, 4'd8, 1'b1, 1'b1);
    // Literal anchors for the reset state and a known glyph
    check("reset_leds_lit", {25'b0, leds_o[0]}, 32'b1111111);
    check("reset_leds_ah", {25'b0, leds_o[2]}, 32'b0000000);

    for (int c = 0; c < 16; c++) step("sweep", 1'b1, 1'b1, 4'(c), 1'b0, 1'b0);

    step("bcd12", 1'b1, 1'b1, 4'd12, 1'b0, 1'b0);
    check("bcd12_lit", {25'b0, leds_o[1]}, 32'b1111111);
    check("bcd12_err", {31'b0, err_o[1]}, 32'd1);
    step("bcd3", 1'b1, 1'b1, 4'd3, 1'b0, 1'b0);
    check("bcd3_lit", {25'b0, leds_o[1]}, 32'b0110000);

    step("prio_lt", 1'b1, 1'b1, 4'd0, 1'b1, 1'b1);
    step("prio_bl", 1'b1, 1'b1, 4'd0, 1'b1, 1'b0);
    step("prio_dec", 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    check("prio_zero_lit", {25'b0, leds_o[0]}, 32'b1000000);

    step("load5", 1'b1, 1'b1, 4'd5, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step("hold", 1'b1, 1'b0, 4'd7, 1'b0, 1'b0);
    check("hold5_lit", {25'b0, leds_o[0]}, 32'b0010010);

    step("pol1", 1'b1, 1'b1, 4'd1, 1'b0, 1'b0);
    check("pol1_lit", {25'b0, leds_o[2]}, 32'b0000110);
    step("polrst", 1'b0, 1'b1, 4'd1, 1'b0, 1'b1);
    step("relload", 1'b1, 1'b1, 4'd6, 1'b0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      step("rand", ($urandom_range(0, 19) != 0), 1'($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
